// File: rtl/instruction_encoder_pkg.sv
// RV32I constants shared between the control decoder and the instruction encoder:
// request formats, decoder ALU codes, major opcodes and the canonical NOP.
package instruction_encoder_pkg;

  typedef enum logic [3:0] {
    FMT_R, FMT_I, FMT_LOAD, FMT_STORE, FMT_BRANCH, FMT_LUI, FMT_AUIPC, FMT_JAL, FMT_JALR
  } fmt_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  function automatic logic [2:0] alu_funct3(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_SUB: return 3'b000;
      ALU_SLL:          return 3'b001;
      ALU_SLT:          return 3'b010;
      ALU_SLTU:         return 3'b011;
      ALU_XOR:          return 3'b100;
      ALU_SRL, ALU_SRA: return 3'b101;
      ALU_OR:           return 3'b110;
      ALU_AND:          return 3'b111;
      default:          return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Request (valid/ready) and IMEM write bus of the instruction encoder.
// master = loader/memory side, slave = encoder side.
interface instruction_encoder_if #(
  parameter int ADDR_W = 10
) ();
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_fmt;
  logic [3:0]        req_alu_op;
  logic [2:0]        req_funct3;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [31:0]       req_imm;
  logic              req_last;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output req_valid, req_fmt, req_alu_op, req_funct3, req_rd, req_rs1, req_rs2,
           req_imm, req_last, mem_ready,
    input  req_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_fmt, req_alu_op, req_funct3, req_rd, req_rs1, req_rs2,
           req_imm, req_last, mem_ready,
    output req_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instruction_encoder_field_enc.sv
// Combinational RV32I field packer: request fields -> {word, illegal, imm_bad}.
// ENC_RANGE_CHECK_EN enables immediate range checking; otherwise imm_bad is tied low.
module instruction_encoder_field_enc
  import instruction_encoder_pkg::*;
(
  input  logic [3:0]  fmt,
  input  logic [3:0]  alu_op,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal,
  output logic        imm_bad
);

  logic [31:0] enc;
  logic        is_shift;
  logic [2:0]  f3_alu;
  logic [6:0]  f7_alu;

  always_comb begin
    is_shift = (alu_op == ALU_SLL) || (alu_op == ALU_SRL) || (alu_op == ALU_SRA);
    f3_alu   = alu_funct3(alu_op);
    f7_alu   = ((alu_op == ALU_SUB) || (alu_op == ALU_SRA)) ? 7'h20 : 7'h00;
    enc      = NOP_WORD;
    illegal  = 1'b0;
    case (fmt)
      FMT_R: begin
        illegal = alu_op > ALU_SLTU;
        enc     = {f7_alu, rs2, rs1, f3_alu, rd, OPC_OP};
      end
      FMT_I: begin
        illegal = (alu_op > ALU_SLTU) || (alu_op == ALU_SUB);
        enc     = is_shift ? {f7_alu, imm[4:0], rs1, f3_alu, rd, OPC_OP_IMM}
                           : {imm[11:0], rs1, f3_alu, rd, OPC_OP_IMM};
      end
      FMT_LOAD:   enc = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
      FMT_STORE:  enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      FMT_BRANCH: enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
      FMT_LUI:    enc = {imm[31:12], rd, OPC_LUI};
      FMT_AUIPC:  enc = {imm[31:12], rd, OPC_AUIPC};
      FMT_JAL:    enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      FMT_JALR:   enc = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
      default:    illegal = 1'b1;
    endcase
    word = illegal ? NOP_WORD : enc;
  end

`ifdef ENC_RANGE_CHECK_EN
  logic s12_ok, s13_ok, s21_ok, range_bad;

  // An N-bit signed value fits when every bit from N-1 upward equals the sign.
  always_comb begin
    s12_ok = (&imm[31:11]) || !(|imm[31:11]);
    s13_ok = (&imm[31:12]) || !(|imm[31:12]);
    s21_ok = (&imm[31:20]) || !(|imm[31:20]);
    case (fmt)
      FMT_I:                         range_bad = is_shift ? (|imm[31:5]) : !s12_ok;
      FMT_LOAD, FMT_STORE, FMT_JALR: range_bad = !s12_ok;
      FMT_BRANCH:                    range_bad = !s13_ok || imm[0];
      FMT_LUI, FMT_AUIPC:            range_bad = |imm[11:0];
      FMT_JAL:                       range_bad = !s21_ok || imm[0];
      default:                       range_bad = 1'b0;
    endcase
    imm_bad = range_bad && !illegal;
  end
`else
  assign imm_bad = 1'b0;
`endif

endmodule

// File: rtl/instruction_encoder.sv
// Session controller: accepts field requests, encodes them and writes words to IMEM
// through a single output register. Build option: ENC_RANGE_CHECK_EN (err[2]).
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  instruction_encoder_if.slave bus,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic [2:0]        err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W:0] LAST_SLOT = CNT_W'(MAX_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e            state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic              mem_we_q;
  logic [31:0]       wdata_q;
  logic [31:0]       enc_word;
  logic              enc_illegal, enc_imm_bad;
  logic              ready, accept, wr_done, overflow, finish, open_session;
  logic [ADDR_W:0]   used;

  instruction_encoder_field_enc u_field_enc (
    .fmt     (bus.req_fmt),
    .alu_op  (bus.req_alu_op),
    .funct3  (bus.req_funct3),
    .rd      (bus.req_rd),
    .rs1     (bus.req_rs1),
    .rs2     (bus.req_rs2),
    .imm     (bus.req_imm),
    .word    (enc_word),
    .illegal (enc_illegal),
    .imm_bad (enc_imm_bad)
  );

  // A word still sitting in the output register already occupies a session slot.
  always_comb begin
    ready        = (state == S_RUN) && (!mem_we_q || bus.mem_ready);
    accept       = bus.req_valid && ready;
    wr_done      = mem_we_q && bus.mem_ready;
    used         = count + CNT_W'(mem_we_q);
    overflow     = accept && !bus.req_last && (used == LAST_SLOT);
    finish       = accept && (bus.req_last || overflow);
    open_session = start && ((state == S_IDLE) || (state == S_DONE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start)   state_nx = S_RUN;
      S_RUN:          if (finish)  state_nx = S_DRAIN;
      S_DRAIN:        if (wr_done) state_nx = S_DONE;
      default:                     state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      count    <= '0;
      err      <= '0;
      mem_we_q <= 1'b0;
      wdata_q  <= '0;
    end else begin
      if (open_session) begin
        addr  <= base_addr;
        count <= '0;
        err   <= '0;
      end else begin
        if (wr_done) begin
          addr  <= addr + ADDR_W'(1);
          count <= count + CNT_W'(1);
        end
        if (accept) err <= err | {enc_imm_bad, overflow, enc_illegal};
      end
      if (accept) begin
        mem_we_q <= 1'b1;
        wdata_q  <= enc_word;
      end else if (wr_done) begin
        mem_we_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata_q;
  assign busy          = (state == S_RUN) || (state == S_DRAIN);
  assign done          = (state == S_DONE);

endmodule

// File: tb/tb_instruction_encoder.sv
// Randomized self-checking bench for instruction_encoder with an ISA-level reference
// encoder and an IMEM write scoreboard; honours ENC_RANGE_CHECK_EN when defined.
module tb_instruction_encoder;

  localparam int ADDR_W = 10;
  localparam int MAX_W  = 4;
`ifdef ENC_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  fmt;
    logic [3:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        last;
  } req_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   count;
  logic              busy, done;
  logic [2:0]        err;

  int   errors = 0;
  int   checks = 0;
  bit   force_en = 1'b1;
  bit   force_val = 1'b1;
  logic [41:0] got_q[$];
  logic [41:0] exp_q[$];

  instruction_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instruction_encoder #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .bus       (bus),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    bus.mem_ready = force_en ? force_val : ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk)
    if (!rst && bus.mem_we === 1'b1 && bus.mem_ready === 1'b1)
      got_q.push_back({bus.mem_addr, bus.mem_wdata});

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic req_t mk(input int fmt, op, f3, rd, rs1, rs2,
                              input logic [31:0] imm, input bit last);
    req_t r;
    r.fmt = 4'(fmt); r.op = 4'(op); r.f3 = 3'(f3);
    r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
    r.imm = imm; r.last = last;
    return r;
  endfunction

  function automatic req_t rand_req(input bit last);
    logic [31:0] imm;
    case ($urandom_range(0, 3))
      0:       imm = $urandom_range(0, 40);
      1:       imm = 32'd0 - $urandom_range(1, 2100);
      2:       imm = $urandom & 32'hFFFF_F000;
      default: imm = $urandom;
    endcase
    return mk($urandom_range(0, 9), $urandom_range(0, 10), $urandom_range(0, 7),
              $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm, last);
  endfunction

  function automatic logic [31:0] pack(input logic [6:0] opc, input logic [4:0] rd,
                                       input logic [2:0] f3, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [6:0] f7);
    return 32'(opc) + (32'(rd) << 7) + (32'(f3) << 12) + (32'(rs1) << 15)
         + (32'(rs2) << 20) + (32'(f7) << 25);
  endfunction

  function automatic void ref_encode(input req_t r, output logic [31:0] w,
                                     output bit ill, output bit bad);
    logic [2:0]  f3_tab[10];
    logic [31:0] im;
    logic [6:0]  f7;
    int          si;
    bit          shift;
    f3_tab = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd4, 3'd1, 3'd5, 3'd5, 3'd2, 3'd3};
    im = r.imm;
    si = $signed(r.imm);
    shift = (r.op == 4'd5) || (r.op == 4'd6) || (r.op == 4'd7);
    f7 = (r.op == 4'd1 || r.op == 4'd7) ? 7'h20 : 7'h00;
    ill = 1'b0; bad = 1'b0; w = 32'h13;
    case (r.fmt)
      4'd0: if (r.op > 9) ill = 1'b1;
            else w = pack(7'h33, r.rd, f3_tab[r.op], r.rs1, r.rs2, f7);
      4'd1: if (r.op > 9 || r.op == 1) ill = 1'b1;
            else if (shift) begin
              w = pack(7'h13, r.rd, f3_tab[r.op], r.rs1, im[4:0], f7);
              bad = im > 31;
            end else begin
              w = pack(7'h13, r.rd, f3_tab[r.op], r.rs1, im[4:0], im[11:5]);
              bad = si < -2048 || si > 2047;
            end
      4'd2: begin w = pack(7'h03, r.rd, r.f3, r.rs1, im[4:0], im[11:5]); bad = si < -2048 || si > 2047; end
      4'd3: begin w = pack(7'h23, im[4:0], r.f3, r.rs1, r.rs2, im[11:5]); bad = si < -2048 || si > 2047; end
      4'd4: begin
        w = pack(7'h63, {im[4:1], im[11]}, r.f3, r.rs1, r.rs2, {im[12], im[10:5]});
        bad = si < -4096 || si > 4095 || im[0];
      end
      4'd5, 4'd6: begin
        w = (im & 32'hFFFF_F000) | (32'(r.rd) << 7) | ((r.fmt == 4'd5) ? 32'h37 : 32'h17);
        bad = (im % 4096) != 0;
      end
      4'd7: begin
        w = (32'({im[20], im[10:1], im[11], im[19:12]}) << 12) | (32'(r.rd) << 7) | 32'h6F;
        bad = si < -(1 << 20) || si >= (1 << 20) || im[0];
      end
      4'd8: begin w = pack(7'h67, r.rd, 3'd0, r.rs1, im[4:0], im[11:5]); bad = si < -2048 || si > 2047; end
      default: ill = 1'b1;
    endcase
    if (ill) bad = 1'b0;
  endfunction

  task automatic do_start(input logic [ADDR_W-1:0] base);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input req_t r, output bit acc);
    bus.req_valid = 1'b1;  bus.req_fmt = r.fmt;  bus.req_alu_op = r.op;
    bus.req_funct3 = r.f3; bus.req_rd = r.rd;    bus.req_rs1 = r.rs1;
    bus.req_rs2 = r.rs2;   bus.req_imm = r.imm;  bus.req_last = r.last;
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = (bus.req_ready === 1'b1);
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    if (!acc) check_eq("accept", 64'(bus.req_ready), 64'd1);
  endtask

  task automatic run_session(input logic [ADDR_W-1:0] base, input req_t reqs[$], input bit stall);
    int unsigned n_acc;
    bit          ended, ill_any, bad_any, ovf, acc, ill, bad;
    logic [31:0] w;
    n_acc = 0; ended = 0; ill_any = 0; bad_any = 0; ovf = 0;
    got_q.delete();
    exp_q.delete();
    force_en = stall;
    force_val = 1'b0;
    do_start(base);
    check_eq("start_busy", 64'(busy), 64'd1);
    check_eq("start_err", 64'(err), 64'd0);
    check_eq("start_count", 64'(count), 64'd0);
    check_eq("start_addr", 64'(bus.mem_addr), 64'(base));
    foreach (reqs[i]) begin
      if (ended) break;
      send(reqs[i], acc);
      if (!acc) break;
      ref_encode(reqs[i], w, ill, bad);
      exp_q.push_back({ADDR_W'(base + n_acc), w});
      n_acc++;
      ill_any |= ill;
      bad_any |= bad;
      if (reqs[i].last) ended = 1'b1;
      else if (n_acc == MAX_W) begin ovf = 1'b1; ended = 1'b1; end
      if (stall && n_acc == 1) begin
        repeat (3) begin
          @(negedge clk);
          check_eq("stall_we", 64'(bus.mem_we), 64'd1);
          check_eq("stall_data", 64'(bus.mem_wdata), 64'(w));
          check_eq("stall_addr", 64'(bus.mem_addr), 64'(base));
          check_eq("stall_ready", 64'(bus.req_ready), 64'd0);
        end
        @(posedge clk); #1;
        force_en = 1'b0;
      end
    end
    for (int k = 0; k < 60 && done !== 1'b1; k++) @(negedge clk);
    check_eq("done", 64'(done), 64'd1);
    check_eq("count", 64'(count), 64'(n_acc));
    check_eq("err", 64'({RANGE_CHK & bad_any, ovf, ill_any}), 64'(err));
    check_eq("done_busy", 64'(busy), 64'd0);
    bus.req_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("done_ready", 64'(bus.req_ready), 64'd0);
      check_eq("done_we", 64'(bus.mem_we), 64'd0);
    end
    bus.req_valid = 1'b0;
    check_eq("n_writes", 64'(got_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i])
      if (i < got_q.size()) check_eq($sformatf("write%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t q[$];
    bit   acc;
    bus.req_valid = 1'b0; bus.req_fmt = '0; bus.req_alu_op = '0; bus.req_funct3 = '0;
    bus.req_rd = '0; bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_imm = '0; bus.req_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_we", 64'(bus.mem_we), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_ready", 64'(bus.req_ready), 64'd0);
    rst = 1'b0;

    q.delete();
    q.push_back(mk(0, 0, 0, 3, 1, 2, 32'd0, 1'b0));
    q.push_back(mk(0, 1, 0, 5, 6, 7, 32'd0, 1'b1));
    run_session(10'h010, q, 1'b0);
    check_eq("add_word", 64'(got_q[0]), 64'({10'h010, 32'h0020_81B3}));
    check_eq("sub_word", 64'(got_q[1]), 64'({10'h011, 32'h4073_02B3}));

    q.delete();
    q.push_back(mk(1, 0, 0, 1, 0, 0, 32'hFFFF_FFFF, 1'b0));
    q.push_back(mk(5, 0, 0, 1, 0, 0, 32'h1234_5000, 1'b0));
    q.push_back(mk(3, 0, 2, 0, 1, 2, 32'd8, 1'b1));
    run_session(10'h020, q, 1'b0);
    check_eq("addi_word", 64'(got_q[0]), 64'({10'h020, 32'hFFF0_0093}));
    check_eq("lui_word", 64'(got_q[1]), 64'({10'h021, 32'h1234_50B7}));
    check_eq("sw_word", 64'(got_q[2]), 64'({10'h022, 32'h0020_A423}));

    q.delete();
    q.push_back(mk(7, 0, 0, 1, 0, 0, 32'd8, 1'b0));
    q.push_back(mk(4, 0, 0, 0, 1, 2, 32'd16, 1'b1));
    run_session(10'h030, q, 1'b1);
    check_eq("jal_word", 64'(got_q[0]), 64'({10'h030, 32'h0080_00EF}));
    check_eq("beq_word", 64'(got_q[1]), 64'({10'h031, 32'h0020_8863}));

    q.delete();
    q.push_back(mk(1, 1, 0, 1, 2, 0, 32'd5, 1'b1));
    run_session(10'h040, q, 1'b0);
    check_eq("nop_word", 64'(got_q[0]), 64'({10'h040, 32'h0000_0013}));
    check_eq("illegal_err", 64'(err), 64'd1);

    q.delete();
    for (int i = 0; i < 6; i++) q.push_back(mk(1, 0, 0, i + 1, 0, 0, 32'(i), 1'b0));
    run_session(10'h050, q, 1'b0);
    check_eq("ovf_err", 64'(err), 64'd2);

    q.delete();
    q.push_back(mk(1, 0, 0, 1, 0, 0, 32'd4096, 1'b1));
    run_session(10'h060, q, 1'b0);
    check_eq("range_err", 64'(err), 64'({RANGE_CHK, 2'b00}));

    for (int s = 0; s < 25; s++) begin
      int unsigned len;
      bit          no_last;
      q.delete();
      no_last = (s % 5 == 4);
      len = no_last ? 5 : $urandom_range(1, 4);
      for (int unsigned i = 0; i < len; i++) q.push_back(rand_req(!no_last && i == len - 1));
      run_session((s == 0) ? 10'h3FE : 10'($urandom_range(0, 1023)), q, 1'b0);
    end

    // reset while a word is pending: one write completed, the next one held
    force_en = 1'b1;
    force_val = 1'b1;
    do_start(10'h100);
    send(mk(0, 0, 0, 1, 2, 3, 32'd0, 1'b0), acc);
    send(mk(0, 4, 0, 4, 5, 6, 32'd0, 1'b0), acc);
    force_val = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_rst_we", 64'(bus.mem_we), 64'd1);
    check_eq("pre_rst_count", 64'(count), 64'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_we", 64'(bus.mem_we), 64'd0);
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_count", 64'(count), 64'd0);
    check_eq("arst_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    force_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("post_rst_idle", 64'({busy, done}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
